// File: rtl/output_packer.sv
// Packs a stream of scalar elements into one wide vector and issues it downstream
// as a single-cycle o_valid pulse once the consumer reports idle.
module output_packer #(
    parameter int numInput   = 10,
    parameter int inputWidth = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rstn,
    input  logic [inputWidth-1:0]          i_data,
    input  logic                           i_valid,
    input  logic                           i_last,
    output logic                           o_ready,
    input  logic                           i_ready,
    output logic [numInput*inputWidth-1:0] o_data,
    output logic                           o_valid,
    output logic [7:0]                     o_count,
    output logic [1:0]                     o_err
);

    // state | meaning
    // FILL  | accepting elements into slot o_count
    // FULL  | vector complete and frozen, waiting for i_ready to issue it
    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    localparam logic [7:0] LAST_IDX = 8'(numInput - 1);

    state_t                  state_q, state_d;
    logic                    accept;
    logic                    last_slot;
    logic                    early_last;
    logic                    issue;
    logic [7:0]              count_q;
    logic [1:0]              err_q;
    logic                    valid_q;
    logic [inputWidth-1:0]   slot_q [numInput];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        last_slot  = 1'b0;
        early_last = 1'b0;
        issue      = 1'b0;
        case (state_q)
            FILL: begin
                if (i_valid) begin
                    accept     = 1'b1;
                    last_slot  = (count_q == LAST_IDX);
                    early_last = i_last && !last_slot;
                    if (last_slot || early_last) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (i_ready) begin
                    issue   = 1'b1;
                    state_d = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count_q <= '0;
            err_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= issue;
            if (issue) begin
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_q + 8'd1;
            end
            // Anything offered while the vector is frozen is lost
            if (i_valid && (state_q == FULL)) begin
                err_q[0] <= 1'b1;
            end
            if (early_last || (last_slot && !i_last)) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    // A short frame clears the unused upper slots so stale data never leaks out
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < numInput; k++) begin
                slot_q[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < numInput; k++) begin
                if (k == int'(count_q)) begin
                    slot_q[k] <= i_data;
                end else if (early_last && (k > int'(count_q))) begin
                    slot_q[k] <= '0;
                end
            end
        end
    end

    for (genvar g = 0; g < numInput; g++) begin : g_pack
        assign o_data[g*inputWidth +: inputWidth] = slot_q[g];
    end

    assign o_ready = (state_q == FILL);
    assign o_valid = valid_q;
    assign o_count = count_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_output_packer.sv
// Directed self-checking bench for output_packer with numInput=10, inputWidth=16.
module tb_output_packer;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int VW = N * W;

    logic          i_clk;
    logic          i_rstn;
    logic [W-1:0]  i_data;
    logic          i_valid;
    logic          i_last;
    logic          o_ready;
    logic          i_ready;
    logic [VW-1:0] o_data;
    logic          o_valid;
    logic [7:0]    o_count;
    logic [1:0]    o_err;

    int checks = 0;
    int errors = 0;

    output_packer #(.numInput(N), .inputWidth(W)) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_last  (i_last),
        .o_ready (o_ready),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_count (o_count),
        .o_err   (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic last);
        i_valid = 1'b1;
        i_data  = d;
        i_last  = last;
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = '0;
    endtask

    task automatic send_frame(input logic [W-1:0] base, input int n, input logic last_on_final);
        for (int k = 0; k < n; k++) begin
            send(base + W'(k), last_on_final && (k == n - 1));
        end
    endtask

    function automatic logic [VW-1:0] vec(input logic [W-1:0] base, input int n);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            if (k < n) v[k*W +: W] = base + W'(k);
        end
        return v;
    endfunction

    initial begin
        int idx;
        int pulses;
        logic acc;
        logic prev_valid;

        i_rstn  = 1'b0;
        i_data  = '0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b0;
        #3;
        chk("rst_data",  o_data,  '0);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_count", o_count, 8'd0);
        chk("rst_err",   o_err,   2'b00);
        chk("rst_ready", o_ready, 1'b1);
        tick();
        i_rstn = 1'b1;

        // basic frame 1..10 with consumer idle
        i_ready = 1'b1;
        send_frame(16'h0001, 10, 1'b1);
        chk("f1_full_ready", o_ready, 1'b0);
        chk("f1_full_count", o_count, 8'd10);
        chk("f1_full_novalid", o_valid, 1'b0);
        tick();
        chk("f1_valid", o_valid, 1'b1);
        chk("f1_data",  o_data,  vec(16'h0001, 10));
        chk("f1_count0", o_count, 8'd0);
        chk("f1_ready", o_ready, 1'b1);
        chk("f1_err",   o_err,   2'b00);
        tick();
        chk("f1_pulse_end", o_valid, 1'b0);

        // consumer busy for 20 cycles
        i_ready = 1'b0;
        send_frame(16'h0100, 10, 1'b1);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("hold_ready", o_ready, 1'b0);
            chk("hold_novalid", o_valid, 1'b0);
            chk("hold_data", o_data, vec(16'h0100, 10));
        end
        i_ready = 1'b1;
        tick();
        chk("hold_valid", o_valid, 1'b1);
        chk("hold_vdata", o_data, vec(16'h0100, 10));
        tick();
        chk("hold_pulse_end", o_valid, 1'b0);

        // drop while FULL
        i_ready = 1'b0;
        send_frame(16'h0200, 10, 1'b1);
        send(16'hBEEF, 1'b0);
        chk("drop_err",   o_err,   2'b01);
        chk("drop_count", o_count, 8'd10);
        chk("drop_data",  o_data,  vec(16'h0200, 10));
        i_ready = 1'b1;
        tick();
        chk("drop_valid", o_valid, 1'b1);
        chk("drop_vdata", o_data,  vec(16'h0200, 10));
        tick();
        send_frame(16'h0300, 10, 1'b1);
        tick();
        chk("after_drop_valid", o_valid, 1'b1);
        chk("after_drop_data",  o_data,  vec(16'h0300, 10));
        chk("err_sticky",       o_err,   2'b01);

        i_rstn = 1'b0;
        #2;
        chk("rst2_err",  o_err,  2'b00);
        chk("rst2_data", o_data, '0);
        tick();
        i_rstn = 1'b1;

        // short frame after a full one: upper slots must be zeroed
        send_frame(16'h0400, 10, 1'b1);
        tick();
        chk("pre_short_valid", o_valid, 1'b1);
        tick();
        send_frame(16'h0011, 4, 1'b1);
        chk("short_ready", o_ready, 1'b0);
        chk("short_count", o_count, 8'd4);
        chk("short_data",  o_data,  vec(16'h0011, 4));
        chk("short_err",   o_err,   2'b10);
        tick();
        chk("short_valid", o_valid, 1'b1);
        chk("short_vdata", o_data,  vec(16'h0011, 4));
        tick();
        chk("short_pulse_end", o_valid, 1'b0);

        // async reset mid-frame
        send_frame(16'h0500, 5, 1'b0);
        #2;
        i_rstn = 1'b0;
        #1;
        chk("mid_rst_data",  o_data,  '0);
        chk("mid_rst_count", o_count, 8'd0);
        chk("mid_rst_err",   o_err,   2'b00);
        chk("mid_rst_ready", o_ready, 1'b1);
        chk("mid_rst_valid", o_valid, 1'b0);
        tick();
        i_rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mid_rst_nopulse", o_valid, 1'b0);
        end
        send_frame(16'h0600, 10, 1'b1);
        tick();
        chk("post_rst_valid", o_valid, 1'b1);
        chk("post_rst_data",  o_data,  vec(16'h0600, 10));
        chk("post_rst_err",   o_err,   2'b00);
        tick();

        // reset while FULL discards the pending vector
        i_ready = 1'b0;
        send_frame(16'h0700, 10, 1'b1);
        i_rstn = 1'b0;
        #1;
        chk("full_rst_ready", o_ready, 1'b1);
        tick();
        i_rstn  = 1'b1;
        i_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("full_rst_nopulse", o_valid, 1'b0);
        end

        // ten elements without i_last: length mismatch but frame completes
        send_frame(16'h0800, 10, 1'b0);
        chk("nolast_err",   o_err,   2'b10);
        chk("nolast_ready", o_ready, 1'b0);
        tick();
        chk("nolast_valid", o_valid, 1'b1);
        chk("nolast_data",  o_data,  vec(16'h0800, 10));

        i_rstn = 1'b0;
        tick();
        i_rstn = 1'b1;

        // back-to-back frames, i_valid held high
        i_ready    = 1'b1;
        idx        = 0;
        pulses     = 0;
        prev_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (idx < 20) begin
                i_valid = 1'b1;
                i_data  = 16'hA000 + W'(idx / 10) * 16'h0100 + W'(idx % 10);
                i_last  = (idx % 10) == 9;
            end else begin
                i_valid = 1'b0;
                i_last  = 1'b0;
            end
            acc = i_valid && o_ready;
            tick();
            if (acc) idx++;
            if (prev_valid) chk("b2b_no_consec", o_valid, 1'b0);
            if (o_valid) begin
                chk("b2b_data", o_data, vec(16'hA000 + W'(pulses) * 16'h0100, 10));
                pulses++;
            end
            prev_valid = o_valid;
            if (pulses == 2) break;
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        chk("b2b_pulses", VW'(pulses), VW'(2));
        chk("b2b_err",    o_err,       2'b01);
        tick();
        chk("b2b_idle", o_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_packer.md
OUTPUT_PACKER -- requirements
Module: output_packer

Interface
REQ-001 Parameter numInput, default 10, number of scalar elements per output vector (2..255).
REQ-002 Parameter inputWidth, default 16, width of each element in bits.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rstn  input  1  asynchronous, active-low reset.
REQ-005 i_data  input  inputWidth  one neuron output element from upstream.
REQ-006 i_valid  input  1  i_data/i_last qualifier; element accepted when i_valid && o_ready at a rising edge.
REQ-007 i_last  input  1  marks final element of a frame; sampled only on acceptance.
REQ-008 o_ready  output  1  high when the block can accept an element.
REQ-009 i_ready  input  1  downstream consumer idle (level); vector may be issued only when high.
REQ-010 o_data  output  numInput*inputWidth  packed vector; element k at bits [k*inputWidth +: inputWidth].
REQ-011 o_valid  output  1  single-cycle pulse; o_data complete and stable in that cycle.
REQ-012 o_count  output  8  number of elements accepted in current frame.
REQ-013 o_err  output  2  sticky errors: bit0 drop, bit1 frame-length mismatch.

Function
REQ-014 FSM states SHALL be FILL and FULL; o_ready SHALL equal (state == FILL).
REQ-015 In FILL, each accepted element SHALL be written to slot o_count and o_count SHALL increment by 1.
REQ-016 Acceptance of slot numInput-1 SHALL move the FSM to FULL on the same edge, regardless of i_last.
REQ-017 If i_last is accepted with o_count < numInput-1, that element SHALL be written, all higher slots zeroed on the same edge, err bit1 set, and FSM moved to FULL.
REQ-018 If slot numInput-1 is accepted with i_last low, err bit1 SHALL be set; the frame still completes.
REQ-019 In FULL, at the first rising edge with i_ready high, o_valid SHALL be registered high for exactly one cycle, FSM SHALL return to FILL and o_count to 0 on that edge.
REQ-020 Minimum latency: last element accepted at edge t -> o_valid high in cycle after edge t+1 (i_ready held high).
REQ-021 o_data SHALL not change from entry to FULL through the end of the o_valid cycle; slots are overwritten only by the next frame's accepted elements.
REQ-022 o_valid SHALL never be high in two consecutive cycles.
REQ-023 i_valid high while o_ready low SHALL drop the element, leave o_data/o_count unchanged and set err bit0.
REQ-024 o_err bits SHALL clear only on reset.
REQ-025 i_ready low in FULL SHALL hold FULL indefinitely with o_ready low.

Reset
REQ-026 While i_rstn low: o_data=0, o_valid=0, o_count=0, o_err=0, FSM=FILL (o_ready=1), independent of i_clk.
REQ-027 Reset asserted mid-frame or in FULL SHALL discard the partial/pending vector; no o_valid issued for it after release.

Verification (numInput=10, inputWidth=16)
REQ-028 Stream 0x0001..0x000A, i_last on 10th, i_ready=1 -> one o_valid pulse, o_data slot k = k+1, o_err=0, o_count returns to 0.
REQ-029 Frame of 10 with i_ready=0 for 20 cycles -> o_ready low, o_data stable, no o_valid until i_ready rises, then exactly one pulse.
REQ-030 i_valid during FULL with i_data=0xBEEF -> element not stored, o_err=2'b01, next frame unaffected.
REQ-031 4 elements 0x0011..0x0014, i_last on 4th -> slots 4..9 zero, o_err=2'b10, o_valid pulses once.
REQ-032 Assert i_rstn low after 5 elements -> all outputs zero, o_ready=1; new 10-element frame then packs correctly.
REQ-033 Back-to-back frames with i_valid continuously high and i_ready=1 -> one o_valid per frame, each o_data matches its own frame.
